// File: rtl/psum_accumulator.sv
// ============================================================================
// psum_accumulator: sums cfg_len unsigned partial sums from one PE column and
// presents the result on a valid/ready handshake. Optional: PSUM_ACC_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module psum_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [2*DATA_WIDTH-1:0] psum_in,
    input  logic                    psum_valid,
    output logic                    in_ready,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEN_WIDTH-1:0]   remain;
    logic                   ovf;
    logic [ACC_WIDTH:0]     sum;
    logic                   carry;
    logic [ACC_WIDTH-1:0]   next_acc;

    // One extra bit captures the carry out of the accumulator width.
    assign sum   = {1'b0, acc} + (ACC_WIDTH+1)'(psum_in);
    assign carry = sum[ACC_WIDTH];

`ifdef PSUM_ACC_SAT_EN
    assign next_acc = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign next_acc = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remain    <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (cfg_len != '0) begin
                            remain   <= cfg_len;
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
                        acc    <= next_acc;
                        remain <= remain - 1'b1;
                        if (carry) begin
                            ovf <= 1'b1;
                        end
                        if (remain == LEN_WIDTH'(1)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A start coinciding with the handshake is dropped here.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = acc;
    assign out_ovf  = ovf;

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator.sv
// ============================================================================
// tb_psum_accumulator: directed self-checking bench for psum_accumulator
// (default widths, plus a 16-bit accumulator instance for overflow).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_psum_accumulator;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [7:0]  cfg_len;
    logic [15:0] psum_in;
    logic        psum_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;

    logic        b_start;
    logic [7:0]  b_cfg_len;
    logic [15:0] b_psum_in;
    logic        b_psum_valid;
    logic        b_in_ready;
    logic [15:0] b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_ovf;

    int n_cmp;
    int n_bad;

`ifdef PSUM_ACC_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'hFFFF;
`else
    localparam logic [15:0] OVF_EXP = 16'd1;
`endif

    psum_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf)
    );

    psum_accumulator #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (16),
        .LEN_WIDTH  (8)
    ) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .cfg_len    (b_cfg_len),
        .psum_in    (b_psum_in),
        .psum_valid (b_psum_valid),
        .in_ready   (b_in_ready),
        .out_data   (b_out_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_ovf    (b_out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; cfg_len = '0; psum_in = '0; psum_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        b_start = 1'b0; b_cfg_len = '0; b_psum_in = '0; b_psum_valid = 1'b0; b_out_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if ({in_ready, out_valid, out_ovf, out_data} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b ovf=%b data=%0d, want all 0",
                     in_ready, out_valid, out_ovf, out_data);
        end
        n_cmp++;
        if ({b_in_ready, b_out_valid, b_out_ovf, b_out_data} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs16: got rdy=%b vld=%b ovf=%b data=%0d, want all 0",
                     b_in_ready, b_out_valid, b_out_ovf, b_out_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [15:0] beats [4];
        beats = '{16'd10, 16'd20, 16'd30, 16'd40};
        out_ready = 1'b1;
        start = 1'b1; cfg_len = 8'd4;
        step();
        start = 1'b0; cfg_len = '0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_early_valid: beat %0d got %b want 0", i, out_valid);
            end
            psum_in = beats[i]; psum_valid = 1'b1;
            step();
        end
        psum_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'd100 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_result: got vld=%b data=%0d ovf=%b rdy=%b want 1/100/0/0",
                     out_valid, out_data, out_ovf, in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_release: got vld=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_bubbles();
        logic [15:0] beats [5];
        logic        vlds  [5];
        beats = '{16'd5, 16'd500, 16'd7, 16'd600, 16'd9};
        vlds  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b0;
        start = 1'b1; cfg_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            psum_in = beats[i]; psum_valid = vlds[i];
            step();
        end
        for (int i = 0; i < 4; i++) begin
            psum_in = 16'd99; psum_valid = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 24'd21 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bubbles_hold: cycle %0d got vld=%b data=%0d rdy=%b want 1/21/0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        psum_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 24'd21) begin
            n_bad++;
            $display("FAIL bubbles_release: got vld=%b data=%0d want 0/21", out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        start = 1'b1; cfg_len = 8'd0;
        step();
        start = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_len: got vld=%b data=%0d ovf=%b rdy=%b want 1/0/0/0",
                     out_valid, out_data, out_ovf, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow16();
        b_out_ready = 1'b0;
        b_start = 1'b1; b_cfg_len = 8'd2;
        step();
        b_start = 1'b0;
        b_psum_in = 16'd65535; b_psum_valid = 1'b1;
        step();
        b_psum_in = 16'd2;
        step();
        b_psum_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (b_out_valid !== 1'b1 || b_out_data !== OVF_EXP || b_out_ovf !== 1'b1) begin
                n_bad++;
                $display("FAIL overflow16: cycle %0d got vld=%b data=%0d ovf=%b want 1/%0d/1",
                         i, b_out_valid, b_out_data, b_out_ovf, OVF_EXP);
            end
            step();
        end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        b_start = 1'b1; b_cfg_len = 8'd1;
        step();
        b_start = 1'b0;
        n_cmp++;
        if (b_out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow16_clear: got ovf=%b want 0", b_out_ovf);
        end
        b_psum_in = 16'd1; b_psum_valid = 1'b1;
        step();
        b_psum_valid = 1'b0;
        n_cmp++;
        if (b_out_valid !== 1'b1 || b_out_data !== 16'd1 || b_out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow16_next: got vld=%b data=%0d ovf=%b want 1/1/0",
                     b_out_valid, b_out_data, b_out_ovf);
        end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    task automatic test_midreset();
        start = 1'b1; cfg_len = 8'd4;
        step();
        start = 1'b0;
        psum_in = 16'd50; psum_valid = 1'b1;
        step();
        psum_in = 16'd60;
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_ovf, out_data} !== 27'd0) begin
            n_bad++;
            $display("FAIL midreset_async: got rdy=%b vld=%b ovf=%b data=%0d want all 0",
                     in_ready, out_valid, out_ovf, out_data);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; cfg_len = 8'd1;
        step();
        start = 1'b0;
        psum_in = 16'd7; psum_valid = 1'b1;
        step();
        psum_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'd7 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_after: got vld=%b data=%0d ovf=%b want 1/7/0",
                     out_valid, out_data, out_ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1; cfg_len = 8'd1;
        step();
        start = 1'b0;
        psum_in = 16'd3; psum_valid = 1'b1;
        step();
        psum_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1; cfg_len = 8'd2;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ignored: got vld=%b rdy=%b want 0/0", out_valid, in_ready);
        end
        out_ready = 1'b0;
        step();
        start = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_data !== 24'd0) begin
            n_bad++;
            $display("FAIL b2b_honoured: got rdy=%b data=%0d want 1/0", in_ready, out_data);
        end
        psum_in = 16'd1000; psum_valid = 1'b1;
        step();
        psum_in = 16'd2345;
        step();
        psum_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 24'd3345) begin
            n_bad++;
            $display("FAIL b2b_result: got vld=%b data=%0d want 1/3345", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_bubbles();
        test_zero_len();
        test_overflow16();
        test_midreset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
